// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing
// Description : VGA raster generator with registered counters, syncs, blank,
//               line/frame strobes and a pix_ce-advanced delayed sync/blank copy.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int SYNC_DELAY = 1
) (
    input  logic       clk_0,
    input  logic       rst,
    input  logic       pix_ce,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       hsync_d,
    output logic       vsync_d,
    output logic       video_on_d,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0]  c_h_max      = 10'(H_TOTAL - 1);
    localparam logic [9:0]  c_v_max      = 10'(V_TOTAL - 1);
    // Window bounds kept at 11 bits so a sync ending exactly at 1024 still compares correctly.
    localparam logic [10:0] c_h_visible  = 11'(H_VISIBLE);
    localparam logic [10:0] c_hs_start   = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] c_hs_end     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] c_v_visible  = 11'(V_VISIBLE);
    localparam logic [10:0] c_vs_start   = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] c_vs_end     = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0]  w_x_next;
    logic [9:0]  w_y_next;
    logic [10:0] w_x_ext;
    logic [10:0] w_y_ext;
    logic        w_hs_next;
    logic        w_vs_next;
    logic        w_vo_next;

    always_comb begin
        w_x_next = pixel_x + 10'd1;
        w_y_next = pixel_y;
        if (pixel_x == c_h_max) begin
            w_x_next = '0;
            w_y_next = (pixel_y == c_v_max) ? '0 : pixel_y + 10'd1;
        end
    end

    // Decode from the upcoming counts so syncs and blank land with the counters.
    always_comb begin
        w_x_ext   = {1'b0, w_x_next};
        w_y_ext   = {1'b0, w_y_next};
        w_hs_next = !((w_x_ext >= c_hs_start) && (w_x_ext < c_hs_end));
        w_vs_next = !((w_y_ext >= c_vs_start) && (w_y_ext < c_vs_end));
        w_vo_next = (w_x_ext < c_h_visible) && (w_y_ext < c_v_visible);
    end

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            pixel_x     <= '0;
            pixel_y     <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_ce) begin
                pixel_x     <= w_x_next;
                pixel_y     <= w_y_next;
                hsync       <= w_hs_next;
                vsync       <= w_vs_next;
                video_on    <= w_vo_next;
                line_start  <= (w_x_next == '0);
                frame_start <= (w_x_next == '0) && (w_y_next == '0);
            end
        end
    end

    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign hsync_d    = hsync;
            assign vsync_d    = vsync;
            assign video_on_d = video_on;
        end else begin : g_delay
            // Each stage holds {hsync, vsync, video_on}.
            logic [2:0] r_stage [SYNC_DELAY];

            always_ff @(posedge clk_0 or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < SYNC_DELAY; i++) begin
                        r_stage[i] <= 3'b110;
                    end
                end else if (pix_ce) begin
                    r_stage[0] <= {hsync, vsync, video_on};
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign hsync_d    = r_stage[SYNC_DELAY-1][2];
            assign vsync_d    = r_stage[SYNC_DELAY-1][1];
            assign video_on_d = r_stage[SYNC_DELAY-1][0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing
// Description : Self-checking bench for vga_timing against a position-count model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing;

    logic clk_0 = 1'b0;
    logic rst   = 1'b0;
    logic pix_ce = 1'b0;

    always #5 clk_0 = ~clk_0;

    // a: default raster, SYNC_DELAY=2.  b/c: small raster (35x21), SYNC_DELAY=0 and 1.
    logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
    logic a_hs, a_vs, a_vo, a_hsd, a_vsd, a_vod, a_ls, a_fs;
    logic b_hs, b_vs, b_vo, b_hsd, b_vsd, b_vod, b_ls, b_fs;
    logic c_hs, c_vs, c_vo, c_hsd, c_vsd, c_vod, c_ls, c_fs;

    vga_timing #(.SYNC_DELAY(2)) u_a (
        .clk_0(clk_0), .rst(rst), .pix_ce(pix_ce), .pixel_x(a_x), .pixel_y(a_y),
        .hsync(a_hs), .vsync(a_vs), .video_on(a_vo), .hsync_d(a_hsd), .vsync_d(a_vsd),
        .video_on_d(a_vod), .line_start(a_ls), .frame_start(a_fs));

    vga_timing #(.H_VISIBLE(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(5),
                 .V_VISIBLE(12), .V_FRONT(3), .V_SYNC(2), .V_BACK(4), .SYNC_DELAY(0)) u_b (
        .clk_0(clk_0), .rst(rst), .pix_ce(pix_ce), .pixel_x(b_x), .pixel_y(b_y),
        .hsync(b_hs), .vsync(b_vs), .video_on(b_vo), .hsync_d(b_hsd), .vsync_d(b_vsd),
        .video_on_d(b_vod), .line_start(b_ls), .frame_start(b_fs));

    vga_timing #(.H_VISIBLE(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(5),
                 .V_VISIBLE(12), .V_FRONT(3), .V_SYNC(2), .V_BACK(4), .SYNC_DELAY(1)) u_c (
        .clk_0(clk_0), .rst(rst), .pix_ce(pix_ce), .pixel_x(c_x), .pixel_y(c_y),
        .hsync(c_hs), .vsync(c_vs), .video_on(c_vo), .hsync_d(c_hsd), .vsync_d(c_vsd),
        .video_on_d(c_vod), .line_start(c_ls), .frame_start(c_fs));

    int n      = 0;   // pixel steps taken since reset released
    bit adv    = 1'b0; // last clock edge was an advancing one
    int total  = 0;
    int passed = 0;
    int fails  = 0;

    // {hsync, vsync, video_on} of the raster position reached after m steps.
    function automatic logic [2:0] decode(input int m, input int hv, input int hf, input int hs,
                                          input int hb, input int vv, input int vf,
                                          input int vs, input int vb);
        int ht = hv + hf + hs + hb;
        int vt = vv + vf + vs + vb;
        int x  = m % ht;
        int y  = (m / ht) % vt;
        if (m == 0) return 3'b110;
        return {!(x >= hv + hf && x < hv + hf + hs), !(y >= vv + vf && y < vv + vf + vs),
                (x < hv && y < vv)};
    endfunction

    function automatic logic [29:0] expect_vec(input int m, input bit a, input int hv,
                                               input int hf, input int hs, input int hb,
                                               input int vv, input int vf, input int vs,
                                               input int vb, input int d);
        int ht = hv + hf + hs + hb;
        int vt = vv + vf + vs + vb;
        int x  = m % ht;
        int y  = (m / ht) % vt;
        logic ls = a && (m > 0) && (x == 0);
        logic fs = ls && (y == 0);
        return {10'(x), 10'(y), decode(m, hv, hf, hs, hb, vv, vf, vs, vb),
                decode((m >= d) ? m - d : 0, hv, hf, hs, hb, vv, vf, vs, vb), ls, fs};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (step %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic check_all();
        check("inst_a", {2'b0, a_x, a_y, a_hs, a_vs, a_vo, a_hsd, a_vsd, a_vod, a_ls, a_fs},
              {2'b0, expect_vec(n, adv, 640, 16, 96, 48, 480, 10, 2, 33, 2)});
        check("inst_b", {2'b0, b_x, b_y, b_hs, b_vs, b_vo, b_hsd, b_vsd, b_vod, b_ls, b_fs},
              {2'b0, expect_vec(n, adv, 20, 4, 6, 5, 12, 3, 2, 4, 0)});
        check("inst_c", {2'b0, c_x, c_y, c_hs, c_vs, c_vo, c_hsd, c_vsd, c_vod, c_ls, c_fs},
              {2'b0, expect_vec(n, adv, 20, 4, 6, 5, 12, 3, 2, 4, 1)});
    endtask

    // Drive pix_ce for one clock edge, advance the model, then compare away from the edge.
    task automatic step(input bit ce);
        pix_ce = ce;
        @(posedge clk_0);
        adv = ce && rst;
        if (adv) n++;
        #1;
        check_all();
    endtask

    function automatic bit rand_ce();
        return $urandom_range(3, 0) != 0;
    endfunction

    initial begin
        int cnt_hs, cnt_ls, cnt_vo, cnt_vs, cnt_fs, first_fs, t0, cyc, steps;
        bit prev, found;

        // Reset held while the clock runs.
        for (int i = 0; i < 4; i++) step(rand_ce());
        rst = 1'b1;
        step(1'b1);
        check("release_x", 32'(a_x), 32'd1);
        check("release_y", 32'(a_y), 32'd0);

        // Random pixel enables.
        for (int i = 0; i < 3000; i++) step(rand_ce());

        // Two full default lines: hsync low 2*96 cycles, two line strobes.
        while (n % 800 != 0) step(1'b1);
        cnt_hs = 0; cnt_ls = 0;
        for (int i = 0; i < 1600; i++) begin
            step(1'b1);
            if (!a_hs) cnt_hs++;
            if (a_ls) cnt_ls++;
        end
        check("a_hsync_low_cycles", 32'(cnt_hs), 32'd192);
        check("a_line_strobes", 32'(cnt_ls), 32'd2);

        // One full small frame.
        while (n % 735 != 0) step(1'b1);
        cnt_vo = 0; cnt_vs = 0; cnt_fs = 0;
        for (int i = 0; i < 735; i++) begin
            step(1'b1);
            if (b_vo) cnt_vo++;
            if (!b_vs) cnt_vs++;
            if (b_fs) cnt_fs++;
        end
        check("b_video_on_cycles", 32'(cnt_vo), 32'd240);
        check("b_vsync_low_cycles", 32'(cnt_vs), 32'd70);
        check("b_frame_strobes", 32'(cnt_fs), 32'd1);

        // Delayed hsync falls exactly two pixel steps after hsync, under random gating.
        prev = a_hs; found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            step(rand_ce());
            if (prev && !a_hs) found = 1'b1;
            prev = a_hs;
        end
        check("a_hs_fall_seen", 32'(found), 32'd1);
        steps = 0; found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            step(rand_ce());
            if (adv) steps++;
            if (!a_hsd) found = 1'b1;
        end
        check("a_hsd_delay_steps", 32'(steps), 32'd2);

        // Alternating enable doubles the frame period in clocks.
        cyc = 0; t0 = -1; found = 1'b0;
        for (int i = 0; i < 5000 && !found; i++) begin
            step(i % 2 == 0);
            cyc++;
            if (b_fs) begin
                if (t0 < 0) t0 = cyc;
                else found = 1'b1;
            end
        end
        check("b_gated_frame_period", 32'(found ? cyc - t0 : 0), 32'd1470);

        // Mid-line reset at default pixel_x=700, asserted between clock edges.
        while (n % 800 != 700) step(1'b1);
        check("pre_reset_a_x", 32'(a_x), 32'd700);
        #2 rst = 1'b0;
        #1;
        n = 0; adv = 1'b0;
        check_all();
        for (int i = 0; i < 3; i++) step(rand_ce());
        rst = 1'b1;
        first_fs = 0;
        for (int i = 1; i <= 740; i++) begin
            step(1'b1);
            if (b_fs && first_fs == 0) first_fs = i;
        end
        check("b_first_frame_after_reset", 32'(first_fs), 32'd735);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
